// File: rtl/cmul_pkg.sv
// Shared geometry, FSM encoding and saturation helper for the complex dot-product sequencer.
package cmul_pkg;

  localparam int unsigned QI    = 3;
  localparam int unsigned QF    = 3;
  localparam int unsigned TAPS  = 4;
  localparam int unsigned W     = QI + QF;
  localparam int unsigned IDX_W = $clog2(TAPS);
  localparam int unsigned ACC_W = W + IDX_W;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(W-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  typedef struct packed {
    logic              clip;
    logic signed [W-1:0] val;
  } sat_t;

  // Clamp an accumulator value into the W-bit result range and report clipping.
  function automatic sat_t sat_w(input logic signed [ACC_W-1:0] v);
    sat_t r;
    r.clip = 1'b0;
    r.val  = W'(v);
    if (v > SAT_MAX) begin
      r.clip = 1'b1;
      r.val  = W'(SAT_MAX);
    end else if (v < SAT_MIN) begin
      r.clip = 1'b1;
      r.val  = W'(SAT_MIN);
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_fixed_complex.sv
// Combinational Q(QI,QF) complex multiply: products floor-rounded (>>> QF) and saturated to W bits.
// ovf = a component was clipped; bad_rep = an operand holds the asymmetric most-negative code.
module mult_fixed_complex #(
  parameter int unsigned QI = 3,
  parameter int unsigned QF = 3
) (
  input  logic signed [QI+QF-1:0] a_re,
  input  logic signed [QI+QF-1:0] a_im,
  input  logic signed [QI+QF-1:0] b_re,
  input  logic signed [QI+QF-1:0] b_im,
  output logic signed [QI+QF-1:0] p_re_c,
  output logic signed [QI+QF-1:0] p_im_c,
  output logic                    ovf_c,
  output logic                    bad_rep_c
);

  localparam int unsigned W  = QI + QF;
  localparam int unsigned DW = 2 * W;
  localparam int unsigned PW = 2 * W + 1;

  localparam logic signed [PW-1:0] P_MAX    = PW'(2**(W-1) - 1);
  localparam logic signed [PW-1:0] P_MIN    = ~P_MAX;
  localparam logic signed [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

  logic signed [DW-1:0] rr, ii, ri, ir;
  logic signed [PW-1:0] sh_re, sh_im;
  logic                 clip_re, clip_im;

  always_comb begin
    rr      = DW'(a_re) * DW'(b_re);
    ii      = DW'(a_im) * DW'(b_im);
    ri      = DW'(a_re) * DW'(b_im);
    ir      = DW'(a_im) * DW'(b_re);
    sh_re   = (PW'(rr) - PW'(ii)) >>> QF;
    sh_im   = (PW'(ri) + PW'(ir)) >>> QF;
    clip_re = (sh_re > P_MAX) || (sh_re < P_MIN);
    clip_im = (sh_im > P_MAX) || (sh_im < P_MIN);

    p_re_c = W'(sh_re);
    if (sh_re > P_MAX)      p_re_c = W'(P_MAX);
    else if (sh_re < P_MIN) p_re_c = W'(P_MIN);

    p_im_c = W'(sh_im);
    if (sh_im > P_MAX)      p_im_c = W'(P_MAX);
    else if (sh_im < P_MIN) p_im_c = W'(P_MIN);

    ovf_c     = clip_re | clip_im;
    bad_rep_c = (a_re == MOST_NEG) | (a_im == MOST_NEG) |
                (b_re == MOST_NEG) | (b_im == MOST_NEG);
  end

endmodule

// File: rtl/cmul_dot_sequencer.sv
// TAPS-point complex dot product sequenced over one shared multiplier, with
// valid/ready on the sample and result sides and per-block sticky flags.
module cmul_dot_sequencer
  import cmul_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    coef_we,
  input  logic [IDX_W-1:0]        coef_addr,
  input  logic signed [W-1:0]     coef_re,
  input  logic signed [W-1:0]     coef_im,
  output logic                    coef_err,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [W-1:0]     s_re,
  input  logic signed [W-1:0]     s_im,
  output logic                    y_valid,
  input  logic                    y_ready,
  output logic signed [W-1:0]     y_re,
  output logic signed [W-1:0]     y_im,
  output logic [2:0]              y_flags
);

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      tap_idx;
  logic signed [W-1:0]   c_re [TAPS];
  logic signed [W-1:0]   c_im [TAPS];
  logic                  prod_valid, prod_ovf, prod_bad;
  logic signed [W-1:0]   prod_re, prod_im;
  logic signed [ACC_W-1:0] acc_re, acc_im;
  logic                  flag_ovf, flag_bad;

  logic signed [W-1:0]   m_re_c, m_im_c;
  logic                  m_ovf_c, m_bad_c;
  logic                  accept_c, last_tap_c, out_fire_c, coef_ok_c;
  sat_t                  sat_re_c, sat_im_c;

  mult_fixed_complex #(.QI(QI), .QF(QF)) u_mult (
    .a_re      (s_re),
    .a_im      (s_im),
    .b_re      (c_re[tap_idx]),
    .b_im      (c_im[tap_idx]),
    .p_re_c    (m_re_c),
    .p_im_c    (m_im_c),
    .ovf_c     (m_ovf_c),
    .bad_rep_c (m_bad_c)
  );

  assign sat_re_c = sat_w(acc_re);
  assign sat_im_c = sat_w(acc_im);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ACC;
    else        state <= state_nxt;
  end

  // Coefficient writes only land between blocks, never alongside the first sample.
  always_comb begin
    state_nxt  = state;
    accept_c   = (state == ST_ACC) && s_valid && s_ready;
    last_tap_c = (tap_idx == IDX_W'(TAPS - 1));
    out_fire_c = (state == ST_OUT) && y_valid && y_ready;
    coef_ok_c  = (state == ST_ACC) && (tap_idx == '0) && !prod_valid && !accept_c;
    case (state)
      ST_ACC:   if (accept_c && last_tap_c) state_nxt = ST_FLUSH;
      ST_FLUSH: state_nxt = ST_OUT;
      ST_OUT:   if (out_fire_c) state_nxt = ST_ACC;
      default:  state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_idx    <= '0;
      prod_valid <= 1'b0;
      prod_re    <= '0;
      prod_im    <= '0;
      prod_ovf   <= 1'b0;
      prod_bad   <= 1'b0;
      acc_re     <= '0;
      acc_im     <= '0;
      flag_ovf   <= 1'b0;
      flag_bad   <= 1'b0;
    end else begin
      prod_valid <= accept_c;
      if (accept_c) begin
        tap_idx  <= last_tap_c ? '0 : tap_idx + IDX_W'(1);
        prod_re  <= m_re_c;
        prod_im  <= m_im_c;
        prod_ovf <= m_ovf_c;
        prod_bad <= m_bad_c;
      end
      if (out_fire_c) begin
        acc_re   <= '0;
        acc_im   <= '0;
        flag_ovf <= 1'b0;
        flag_bad <= 1'b0;
      end else if (prod_valid) begin
        acc_re   <= acc_re + ACC_W'(prod_re);
        acc_im   <= acc_im + ACC_W'(prod_im);
        flag_ovf <= flag_ovf | prod_ovf;
        flag_bad <= flag_bad | prod_bad;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        c_re[i] <= '0;
        c_im[i] <= '0;
      end
    end else if (coef_we && coef_ok_c) begin
      c_re[coef_addr] <= coef_re;
      c_im[coef_addr] <= coef_im;
    end
  end

  // Result is captured one cycle into OUT so the flushed product is included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_err <= 1'b0;
      s_ready  <= 1'b0;
      y_valid  <= 1'b0;
      y_re     <= '0;
      y_im     <= '0;
      y_flags  <= '0;
    end else begin
      coef_err <= coef_we && !coef_ok_c;
      s_ready  <= (state_nxt == ST_ACC);
      if (state == ST_OUT) begin
        if (!y_valid) begin
          y_valid <= 1'b1;
          y_re    <= sat_re_c.val;
          y_im    <= sat_im_c.val;
          y_flags <= {sat_re_c.clip | sat_im_c.clip, flag_bad, flag_ovf};
        end else if (y_ready) begin
          y_valid <= 1'b0;
        end
      end
    end
  end

endmodule
